// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared definitions for the execute stage.
//   ALUOp encodings, R-type funct codes and the multiply/divide FSM states.
package ex_stage_pkg;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ORI   = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: bundles the ID/EX inputs, writeback forwarding inputs and the
// EX/MEM outputs of the execute stage.
//   master : drives ID/EX and WB signals, observes stall and MEM_ outputs.
//   slave  : the execute stage itself.
interface ex_stage_if;
    logic        EX_RegDst;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic        EX_MemWrite;
    logic        EX_ALUSrc;
    logic        EX_MemtoReg;
    logic [1:0]  EX_ALUOp;
    logic [31:0] EX_rdata1;
    logic [31:0] EX_rdata2;
    logic [31:0] EX_const_or_addr;
    logic [4:0]  EX_rs;
    logic [4:0]  EX_rt;
    logic [4:0]  EX_rd;
    logic        WB_RegWrite;
    logic [4:0]  WB_wreg;
    logic [31:0] WB_wdata;
    logic        stall;
    logic        MEM_RegWrite;
    logic        MEM_MemRead;
    logic        MEM_MemWrite;
    logic        MEM_MemtoReg;
    logic [31:0] MEM_alu_result;
    logic [31:0] MEM_wdata;
    logic [4:0]  MEM_wreg;

    modport master (
        output EX_RegDst, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_MemtoReg,
        output EX_ALUOp, EX_rdata1, EX_rdata2, EX_const_or_addr, EX_rs, EX_rt, EX_rd,
        output WB_RegWrite, WB_wreg, WB_wdata,
        input  stall, MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg,
        input  MEM_alu_result, MEM_wdata, MEM_wreg
    );

    modport slave (
        input  EX_RegDst, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_MemtoReg,
        input  EX_ALUOp, EX_rdata1, EX_rdata2, EX_const_or_addr, EX_rs, EX_rt, EX_rd,
        input  WB_RegWrite, WB_wreg, WB_wdata,
        output stall, MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg,
        output MEM_alu_result, MEM_wdata, MEM_wreg
    );
endinterface

// File: rtl/ex_stage_muldiv.sv
// muldiv_unit: iterative 32-step unsigned multiply (shift-add) and divide
// (restoring), holding HI/LO.
//   clk, rst      : clock, synchronous active-low reset (aborts any operation)
//   start_mul_i   : begin multu with op_a_i * op_b_i
//   start_div_i   : begin divu with op_a_i / op_b_i
//   busy_o        : FSM not idle
//   hi_o, lo_o    : HI/LO registers
module muldiv_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_mul_i,
    input  logic        start_div_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic        busy_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    md_state_e   state_q, state_d;
    logic [5:0]  cnt_q;
    // Upper half: partial product / remainder; lower half: multiplier / quotient.
    logic [63:0] work_q;
    // Multiplicand or divisor.
    logic [31:0] opnd_q;
    logic [31:0] hi_q, lo_q;
    logic [63:0] step_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_shift_s;
    logic [31:0] div_diff_s;
    logic        last_step_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d     = state_q;
        last_step_s = (cnt_q == 6'd31);
        case (state_q)
            MD_IDLE: begin
                if (start_mul_i) begin
                    state_d = MD_MUL;
                end else if (start_div_i) begin
                    state_d = MD_DIV;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_MUL, MD_DIV: begin
                if (last_step_s) begin
                    state_d = MD_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        case (state_q)
            MD_IDLE: busy_o = 1'b0;
            default: busy_o = 1'b1;
        endcase
    end

    // One iteration of the selected algorithm
    always_comb begin
        mul_sum_s   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift_s = {work_q[63:32], work_q[31]};
        // Only meaningful when no borrow, and then it fits in 32 bits.
        div_diff_s  = div_shift_s[31:0] - opnd_q;
        case (state_q)
            MD_MUL: step_s = {mul_sum_s, work_q[31:1]};
            MD_DIV: begin
                if (div_shift_s >= {1'b0, opnd_q}) begin
                    step_s = {div_diff_s, work_q[30:0], 1'b1};
                end else begin
                    step_s = {div_shift_s[31:0], work_q[30:0], 1'b0};
                end
            end
            default: step_s = work_q;
        endcase
    end

    // Operand latch, iteration and HI/LO update
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= 6'd0;
            work_q <= 64'd0;
            opnd_q <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    cnt_q <= 6'd0;
                    if (start_mul_i) begin
                        work_q <= {32'd0, op_b_i};
                        opnd_q <= op_a_i;
                    end else if (start_div_i) begin
                        work_q <= {32'd0, op_a_i};
                        opnd_q <= op_b_i;
                    end else begin
                        work_q <= work_q;
                        opnd_q <= opnd_q;
                    end
                end
                MD_MUL, MD_DIV: begin
                    work_q <= step_s;
                    if (last_step_s) begin
                        cnt_q <= 6'd0;
                        hi_q  <= step_s[63:32];
                        lo_q  <= step_s[31:0];
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                default: cnt_q <= 6'd0;
            endcase
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: pipeline execute stage with operand forwarding, ALU, an iterative
// multiply/divide unit and the EX/MEM pipeline register.
//   clk  : clock
//   rst  : synchronous active-low reset
//   bus  : ID/EX inputs, WB forwarding inputs, stall and MEM_ outputs
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    ex_stage_if.slave bus
);
    logic [31:0] op_a_s, op_rt_s, op_b_s, alu_res_s;
    logic [5:0]  funct_s;
    logic        rw_ok_s, uses_md_s, is_mul_s, is_div_s;
    logic        md_busy_s, stall_s;
    logic [31:0] hi_s, lo_s;

    logic        mem_regwrite_q, mem_memread_q, mem_memwrite_q, mem_memtoreg_q;
    logic [31:0] mem_alu_result_q, mem_wdata_q;
    logic [4:0]  mem_wreg_q;

    // A load in MEM has no value yet, so only ALU results are forwarded from MEM.
    function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] rf_val,
                                        input logic m_rw, input logic m_m2r,
                                        input logic [4:0] m_reg, input logic [31:0] m_val,
                                        input logic w_rw, input logic [4:0] w_reg,
                                        input logic [31:0] w_val);
        logic [31:0] r;
        if (m_rw && !m_m2r && (m_reg != 5'd0) && (m_reg == src)) begin
            r = m_val;
        end else if (w_rw && (w_reg != 5'd0) && (w_reg == src)) begin
            r = w_val;
        end else begin
            r = rf_val;
        end
        return r;
    endfunction

    // Operand forwarding and B-operand select
    always_comb begin
        op_a_s  = fwd(bus.EX_rs, bus.EX_rdata1, mem_regwrite_q, mem_memtoreg_q, mem_wreg_q,
                      mem_alu_result_q, bus.WB_RegWrite, bus.WB_wreg, bus.WB_wdata);
        op_rt_s = fwd(bus.EX_rt, bus.EX_rdata2, mem_regwrite_q, mem_memtoreg_q, mem_wreg_q,
                      mem_alu_result_q, bus.WB_RegWrite, bus.WB_wreg, bus.WB_wdata);
        if (bus.EX_ALUSrc) begin
            op_b_s = bus.EX_const_or_addr;
        end else begin
            op_b_s = op_rt_s;
        end
    end

    // ALU and funct decode
    always_comb begin
        alu_res_s = 32'd0;
        rw_ok_s   = 1'b1;
        uses_md_s = 1'b0;
        is_mul_s  = 1'b0;
        is_div_s  = 1'b0;
        funct_s   = bus.EX_const_or_addr[5:0];
        case (bus.EX_ALUOp)
            ALU_ADD: alu_res_s = op_a_s + op_b_s;
            ALU_SUB: alu_res_s = op_a_s - op_b_s;
            ALU_ORI: alu_res_s = op_a_s | op_b_s;
            ALU_RTYPE: begin
                case (funct_s)
                    FUNCT_ADD: alu_res_s = op_a_s + op_b_s;
                    FUNCT_SUB: alu_res_s = op_a_s - op_b_s;
                    FUNCT_AND: alu_res_s = op_a_s & op_b_s;
                    FUNCT_OR:  alu_res_s = op_a_s | op_b_s;
                    FUNCT_SLT: alu_res_s = ($signed(op_a_s) < $signed(op_b_s)) ? 32'd1 : 32'd0;
                    FUNCT_MULTU: begin
                        rw_ok_s   = 1'b0;
                        uses_md_s = 1'b1;
                        is_mul_s  = 1'b1;
                    end
                    FUNCT_DIVU: begin
                        rw_ok_s   = 1'b0;
                        uses_md_s = 1'b1;
                        is_div_s  = 1'b1;
                    end
                    FUNCT_MFHI: begin
                        alu_res_s = hi_s;
                        uses_md_s = 1'b1;
                    end
                    FUNCT_MFLO: begin
                        alu_res_s = lo_s;
                        uses_md_s = 1'b1;
                    end
                    default: rw_ok_s = 1'b0;
                endcase
            end
            default: rw_ok_s = 1'b0;
        endcase
        // Stall is suppressed in the reset cycle so it reads 0 while rst is low.
        stall_s = rst && md_busy_s && uses_md_s;
    end

    muldiv_unit u_muldiv (
        .clk         (clk),
        .rst         (rst),
        .start_mul_i (is_mul_s && !md_busy_s),
        .start_div_i (is_div_s && !md_busy_s),
        .op_a_i      (op_a_s),
        .op_b_i      (op_b_s),
        .busy_o      (md_busy_s),
        .hi_o        (hi_s),
        .lo_o        (lo_s)
    );

    // EX/MEM pipeline register; a stall inserts a bubble
    always_ff @(posedge clk) begin
        if (!rst || stall_s) begin
            mem_regwrite_q   <= 1'b0;
            mem_memread_q    <= 1'b0;
            mem_memwrite_q   <= 1'b0;
            mem_memtoreg_q   <= 1'b0;
            mem_alu_result_q <= 32'd0;
            mem_wdata_q      <= 32'd0;
            mem_wreg_q       <= 5'd0;
        end else begin
            mem_regwrite_q   <= bus.EX_RegWrite && rw_ok_s;
            mem_memread_q    <= bus.EX_MemRead;
            mem_memwrite_q   <= bus.EX_MemWrite;
            mem_memtoreg_q   <= bus.EX_MemtoReg;
            mem_alu_result_q <= alu_res_s;
            mem_wdata_q      <= op_rt_s;
            mem_wreg_q       <= bus.EX_RegDst ? bus.EX_rd : bus.EX_rt;
        end
    end

    assign bus.stall          = stall_s;
    assign bus.MEM_RegWrite   = mem_regwrite_q;
    assign bus.MEM_MemRead    = mem_memread_q;
    assign bus.MEM_MemWrite   = mem_memwrite_q;
    assign bus.MEM_MemtoReg   = mem_memtoreg_q;
    assign bus.MEM_alu_result = mem_alu_result_q;
    assign bus.MEM_wdata      = mem_wdata_q;
    assign bus.MEM_wreg       = mem_wreg_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed, table-driven bench for ex_stage plus hand-written
// multiply/divide, stall and reset sequences.
module tb_ex_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ex_stage_if bus ();

    ex_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  aluop;
        logic        alusrc, regdst, regwrite, memread, memwrite, memtoreg;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
        logic        wb_rw;
        logic [4:0]  wb_wreg;
        logic [31:0] wb_wdata;
        logic [31:0] e_res;
        logic [4:0]  e_wreg;
        logic        e_rw, e_mr, e_mw, e_m2r;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t rv(input logic [5:0] funct, input logic [4:0] rs, rt, rd,
                                input logic [31:0] a, b, input logic wb_rw,
                                input logic [4:0] wb_wreg, input logic [31:0] wb_wdata,
                                input logic [31:0] e_res, input logic e_rw,
                                input logic [31:0] e_wdata);
        vec_t v;
        v.aluop = 2'b10; v.alusrc = 1'b0; v.regdst = 1'b1; v.regwrite = 1'b1;
        v.memread = 1'b0; v.memwrite = 1'b0; v.memtoreg = 1'b0;
        v.rs = rs; v.rt = rt; v.rd = rd; v.a = a; v.b = b; v.imm = {26'd0, funct};
        v.wb_rw = wb_rw; v.wb_wreg = wb_wreg; v.wb_wdata = wb_wdata;
        v.e_res = e_res; v.e_wreg = rd; v.e_rw = e_rw;
        v.e_mr = 1'b0; v.e_mw = 1'b0; v.e_m2r = 1'b0; v.e_wdata = e_wdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.EX_ALUOp = v.aluop; bus.EX_ALUSrc = v.alusrc; bus.EX_RegDst = v.regdst;
        bus.EX_RegWrite = v.regwrite; bus.EX_MemRead = v.memread;
        bus.EX_MemWrite = v.memwrite; bus.EX_MemtoReg = v.memtoreg;
        bus.EX_rs = v.rs; bus.EX_rt = v.rt; bus.EX_rd = v.rd;
        bus.EX_rdata1 = v.a; bus.EX_rdata2 = v.b; bus.EX_const_or_addr = v.imm;
        bus.WB_RegWrite = v.wb_rw; bus.WB_wreg = v.wb_wreg; bus.WB_wdata = v.wb_wdata;
    endtask

    task automatic drive_r(input logic [5:0] funct, input logic [4:0] rs, rt, rd,
                           input logic [31:0] a, b);
        apply(rv(funct, rs, rt, rd, a, b, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0));
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts consecutive stalled cycles, bounded so a stuck stall cannot hang.
    task automatic count_stall(output int cnt, output logic bubble_ok);
        cnt = 0;
        bubble_ok = 1'b1;
        #1;
        while (bus.stall === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
            #1;
            if (bus.MEM_RegWrite !== 1'b0 || bus.MEM_alu_result !== 32'd0 ||
                bus.MEM_wreg !== 5'd0)
                bubble_ok = 1'b0;
        end
    endtask

    task automatic chk_mem_zero(input string tag);
        chk({tag, " RegWrite"}, {31'd0, bus.MEM_RegWrite}, 32'd0);
        chk({tag, " ctrl"}, {29'd0, bus.MEM_MemRead, bus.MEM_MemWrite, bus.MEM_MemtoReg}, 32'd0);
        chk({tag, " result"}, bus.MEM_alu_result, 32'd0);
        chk({tag, " wdata"}, bus.MEM_wdata, 32'd0);
        chk({tag, " wreg"}, {27'd0, bus.MEM_wreg}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cnt;
        logic bok;
        n_checks = 0;
        n_fail   = 0;

        //            funct  rs  rt  rd  a             b             wbrw wbreg wbdata   res           rw    wdata
        vecs.push_back(rv(6'h20, 5'd1,  5'd2,  5'd3,  32'd5,        32'd7,        1'b0, 5'd0,  32'd0,    32'd12,       1'b1, 32'd7));
        vecs.push_back(rv(6'h22, 5'd3,  5'd4,  5'd5,  32'd0,        32'd2,        1'b0, 5'd0,  32'd0,    32'd10,       1'b1, 32'd2));
        vecs.push_back(rv(6'h22, 5'd6,  5'd7,  5'd8,  32'd0,        32'd8,        1'b1, 5'd6,  32'd50,   32'd42,       1'b1, 32'd8));
        vecs.push_back(rv(6'h20, 5'd8,  5'd9,  5'd0,  32'd0,        32'd1,        1'b1, 5'd8,  32'd99,   32'd43,       1'b1, 32'd1));
        vecs.push_back(rv(6'h20, 5'd0,  5'd11, 5'd24, 32'd7,        32'd3,        1'b1, 5'd0,  32'd1000, 32'd10,       1'b1, 32'd3));
        vecs.push_back(rv(6'h24, 5'd12, 5'd13, 5'd14, 32'hFF,       32'd0,        1'b1, 5'd13, 32'hF0,   32'hF0,       1'b1, 32'hF0));
        vecs.push_back(rv(6'h25, 5'd15, 5'd14, 5'd16, 32'h0F,       32'd0,        1'b0, 5'd0,  32'd0,    32'hFF,       1'b1, 32'hF0));
        vecs.push_back(rv(6'h2A, 5'd17, 5'd18, 5'd19, 32'hFFFFFFFF, 32'd1,        1'b0, 5'd0,  32'd0,    32'd1,        1'b1, 32'd1));
        vecs.push_back(rv(6'h2A, 5'd17, 5'd18, 5'd19, 32'd1,        32'hFFFFFFFF, 1'b0, 5'd0,  32'd0,    32'd0,        1'b1, 32'hFFFFFFFF));
        // ori, sub with store controls, load (MemtoReg blocks MEM forwarding next)
        vecs.push_back('{2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd20, 5'd21, 5'd0,
                         32'hF0, 32'h55, 32'h0F, 1'b0, 5'd0, 32'd0,
                         32'hFF, 5'd21, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55});
        vecs.push_back('{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd25, 5'd26, 5'd0,
                         32'd0, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0,
                         32'hFFFFFFFF, 5'd26, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1});
        vecs.push_back('{2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd27, 5'd22, 5'd0,
                         32'h100, 32'h77, 32'hFFFFFFFC, 1'b0, 5'd0, 32'd0,
                         32'hFC, 5'd22, 1'b1, 1'b1, 1'b0, 1'b1, 32'h77});
        vecs.push_back(rv(6'h20, 5'd22, 5'd23, 5'd28, 32'd5,        32'd5,        1'b0, 5'd0,  32'd0,    32'd10,       1'b1, 32'd5));
        vecs.push_back(rv(6'h3F, 5'd1,  5'd2,  5'd29, 32'd3,        32'd4,        1'b0, 5'd0,  32'd0,    32'd0,        1'b0, 32'd4));
        vecs.push_back(rv(6'h20, 5'd1,  5'd2,  5'd30, 32'hFFFFFFFF, 32'd2,        1'b0, 5'd0,  32'd0,    32'd1,        1'b1, 32'd2));

        // Reset with a live instruction presented: outputs must stay cleared.
        rst = 1'b0;
        drive_r(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
        tick();
        tick();
        chk_mem_zero("reset");
        chk("reset stall", {31'd0, bus.stall}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            #1;
            chk($sformatf("v%0d stall", i), {31'd0, bus.stall}, 32'd0);
            tick();
            chk($sformatf("v%0d result", i), bus.MEM_alu_result, vecs[i].e_res);
            chk($sformatf("v%0d wreg", i), {27'd0, bus.MEM_wreg}, {27'd0, vecs[i].e_wreg});
            chk($sformatf("v%0d regwrite", i), {31'd0, bus.MEM_RegWrite}, {31'd0, vecs[i].e_rw});
            chk($sformatf("v%0d ctrl", i), {29'd0, bus.MEM_MemRead, bus.MEM_MemWrite, bus.MEM_MemtoReg},
                {29'd0, vecs[i].e_mr, vecs[i].e_mw, vecs[i].e_m2r});
            chk($sformatf("v%0d wdata", i), bus.MEM_wdata, vecs[i].e_wdata);
        end

        // multu 0xFFFFFFFF * 2 followed by mflo: 32 stalled cycles
        drive_r(6'h19, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 32'd2);
        #1;
        chk("multu stall", {31'd0, bus.stall}, 32'd0);
        tick();
        chk("multu regwrite", {31'd0, bus.MEM_RegWrite}, 32'd0);
        drive_r(6'h12, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0);
        count_stall(cnt, bok);
        chk("mul stall cycles", cnt, 32'd32);
        chk("mul bubble", {31'd0, bok}, 32'd1);
        tick();
        chk("mflo result", bus.MEM_alu_result, 32'hFFFFFFFE);
        chk("mflo regwrite", {31'd0, bus.MEM_RegWrite}, 32'd1);
        chk("mflo wreg", {27'd0, bus.MEM_wreg}, 32'd5);
        drive_r(6'h10, 5'd0, 5'd0, 5'd6, 32'd0, 32'd0);
        #1;
        chk("mfhi stall", {31'd0, bus.stall}, 32'd0);
        tick();
        chk("mfhi result", bus.MEM_alu_result, 32'd1);

        // divu 100/7 with an unrelated add issued while the unit is busy
        drive_r(6'h1B, 5'd1, 5'd2, 5'd0, 32'd100, 32'd7);
        tick();
        drive_r(6'h20, 5'd3, 5'd4, 5'd7, 32'd3, 32'd4);
        #1;
        chk("busy add stall", {31'd0, bus.stall}, 32'd0);
        tick();
        chk("busy add result", bus.MEM_alu_result, 32'd7);
        drive_r(6'h12, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0);
        count_stall(cnt, bok);
        chk("div stall cycles", cnt, 32'd31);
        tick();
        chk("divu lo", bus.MEM_alu_result, 32'd14);
        drive_r(6'h10, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0);
        tick();
        chk("divu hi", bus.MEM_alu_result, 32'd2);

        // divu 9/0
        drive_r(6'h1B, 5'd1, 5'd2, 5'd0, 32'd9, 32'd0);
        tick();
        drive_r(6'h10, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0);
        count_stall(cnt, bok);
        chk("div0 stall cycles", cnt, 32'd32);
        tick();
        chk("div0 hi", bus.MEM_alu_result, 32'd9);
        drive_r(6'h12, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0);
        tick();
        chk("div0 lo", bus.MEM_alu_result, 32'hFFFFFFFF);

        // Reset in the middle of a multu
        drive_r(6'h19, 5'd1, 5'd2, 5'd0, 32'd3, 32'd5);
        tick();
        drive_r(6'h10, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0);
        for (int k = 0; k < 8; k++) tick();
        #1;
        chk("pre-reset stall", {31'd0, bus.stall}, 32'd1);
        rst = 1'b0;
        #1;
        chk("in-reset stall", {31'd0, bus.stall}, 32'd0);
        tick();
        chk_mem_zero("mid reset");
        rst = 1'b1;
        #1;
        chk("post-reset stall", {31'd0, bus.stall}, 32'd0);
        tick();
        chk("post-reset hi", bus.MEM_alu_result, 32'd0);
        chk("post-reset mfhi rw", {31'd0, bus.MEM_RegWrite}, 32'd1);
        drive_r(6'h12, 5'd0, 5'd0, 5'd5, 32'd0, 32'd0);
        tick();
        chk("post-reset lo", bus.MEM_alu_result, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on posedge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-low (0 at posedge = reset).
REQ-003 SHALL have: EX_RegDst, EX_RegWrite, EX_MemRead, EX_MemWrite, EX_ALUSrc, EX_MemtoReg  in  1 each  control bits from ID/EX register.
REQ-004 SHALL have: EX_ALUOp  in  2  00 add, 01 sub, 10 R-type by funct, 11 or-immediate.
REQ-005 SHALL have: EX_rdata1, EX_rdata2, EX_const_or_addr  in  32 each  operands, sign-extended immediate; funct = EX_const_or_addr[5:0].
REQ-006 SHALL have: EX_rs, EX_rt, EX_rd  in  5 each  register numbers.
REQ-007 SHALL have: WB_RegWrite  in  1,  WB_wreg  in  5,  WB_wdata  in  32  writeback-stage result for forwarding.
REQ-008 SHALL have: stall  out  1  holds PC, IF/ID, ID/EX when 1.
REQ-009 SHALL have: MEM_RegWrite, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg  out  1 each;  MEM_alu_result  out  32;  MEM_wdata  out  32 (forwarded rt);  MEM_wreg  out  5  registered EX/MEM outputs.

Function
REQ-010 SHALL forward operand A: MEM_RegWrite && MEM_MemtoReg==0 && MEM_wreg!=0 && MEM_wreg==EX_rs -> MEM_alu_result; else WB_RegWrite && WB_wreg!=0 && WB_wreg==EX_rs -> WB_wdata; else EX_rdata1.
REQ-011 SHALL forward rt value identically (EX_rt vs. EX_rdata2); MEM priority over WB.
REQ-012 SHALL use B = EX_ALUSrc ? EX_const_or_addr : forwarded rt.
REQ-013 SHALL for ALUOp=10 decode funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0/1), 0x19 multu, 0x1B divu, 0x10 mfhi, 0x12 mflo; other funct -> result 0, RegWrite forced 0.
REQ-014 SHALL wrap add/sub modulo 2^32, no overflow trap.
REQ-015 SHALL select MEM_wreg = EX_RegDst ? EX_rd : EX_rt.
REQ-016 SHALL keep HI, LO (32 each) and a muldiv FSM: IDLE, MUL, DIV; 6-bit iteration counter.
REQ-017 SHALL on multu/divu in EX with FSM IDLE latch forwarded operands, go MUL/DIV, counter=0; the instruction passes to MEM with RegWrite=0.
REQ-018 SHALL perform one shift-add (MUL) or restoring-subtract (DIV) step per cycle; after 32 steps load HI/LO and return to IDLE.
REQ-019 SHALL produce multu: {HI,LO}=A*B unsigned 64-bit; divu: LO=A/B, HI=A%B unsigned.
REQ-020 SHALL on divide by zero give LO=0xFFFFFFFF, HI=A, still 32 cycles.
REQ-021 SHALL assert stall combinationally when FSM not IDLE and EX holds multu, divu, mfhi or mflo; otherwise 0.
REQ-022 SHALL while stall=1 load a bubble into EX/MEM (all MEM_ control bits 0, data 0); FSM keeps iterating.
REQ-023 SHALL write mfhi/mflo result (HI/LO) with RegWrite=1 once not stalled.
REQ-024 SHALL latency: non-muldiv result appears on MEM_ outputs the cycle after the instruction is in EX.
REQ-025 SHALL let unrelated instructions proceed while FSM busy.

Reset
REQ-026 SHALL on rst==0 at posedge clear all MEM_ outputs to 0, HI=LO=0, counter=0, FSM=IDLE; aborts any in-progress muldiv.
REQ-027 SHALL drive stall=0 during reset cycle outputs and after reset until a REQ-021 condition.

Structure
REQ-028 SHALL place ALUOp codes, funct codes and FSM state encodings in a shared definitions package/header.
REQ-029 SHALL isolate the iterative multiply/divide (operands, FSM, counter, HI/LO) in one sub-module muldiv_unit.

Verification
REQ-030 add: rdata1=5, rdata2=7, ALUOp=10, funct=0x20, rd=3 -> next cycle MEM_alu_result=12, MEM_wreg=3, MEM_RegWrite=1.
REQ-031 forward: prior add writes r3=12; next sub rs=3, rdata1=0, rt=r4=2 -> result 10; same with WB-only match uses WB_wdata; rs=0 never forwarded.
REQ-032 multu 0xFFFFFFFF*2 then mflo next -> stall=1 for 32 cycles, then MEM_alu_result=0xFFFFFFFE; mfhi -> 1.
REQ-033 divu 100/7 -> LO=14, HI=2; divu 9/0 -> LO=0xFFFFFFFF, HI=9.
REQ-034 rst=0 at posedge during cycle 10 of a multu -> all outputs 0, HI=LO=0, stall=0 next cycle.
REQ-035 slt -1,1 -> 1; ori ALUOp=11, A=0xF0, imm=0x0F -> 0xFF; undefined funct -> RegWrite=0.
